// File: rtl/simd_add_sub_pipe.sv
// SIMD add/subtract with 1/2/4 run-time lanes, accumulator and
// configurable output pipeline; valid travels with each sample.
module simd_add_sub_pipe #(
  parameter int DATA_WIDTH  = 48,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  in_valid,
  input  logic                  opmode,
  input  logic                  acc_en,
  input  logic [1:0]            simd,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] z,
  output logic [3:0]            cout,
  output logic                  out_valid
);
  localparam int DW = DATA_WIDTH;
  localparam int H  = DW / 2;
  localparam int Q  = DW / 4;

  logic [DW-1:0] r_z;
  logic [3:0]    r_cout;
  logic          r_v;

  logic [DW-1:0] w_a;
  logic [DW:0]   w_s1;
  logic [H:0]    w_s2 [2];
  logic [Q:0]    w_s4 [4];
  logic [DW-1:0] w_z;
  logic [3:0]    w_c;

  // The stage-1 result register doubles as the accumulator.
  assign w_a = acc_en ? r_z : x;

  // Full-width lane; the top bit is carry (add) or borrow (sub).
  assign w_s1 = opmode
    ? ({1'b0, w_a} - {1'b0, y} - {{DW{1'b0}}, cin})
    : ({1'b0, w_a} + {1'b0, y} + {{DW{1'b0}}, cin});

  for (genvar k = 0; k < 2; k++) begin : g_two
    logic w_ci;
    assign w_ci = (k == 0) ? cin : 1'b0;
    assign w_s2[k] = opmode
      ? ({1'b0, w_a[k*H +: H]} - {1'b0, y[k*H +: H]}
         - {{H{1'b0}}, w_ci})
      : ({1'b0, w_a[k*H +: H]} + {1'b0, y[k*H +: H]}
         + {{H{1'b0}}, w_ci});
  end

  for (genvar k = 0; k < 4; k++) begin : g_four
    logic w_ci;
    assign w_ci = (k == 0) ? cin : 1'b0;
    assign w_s4[k] = opmode
      ? ({1'b0, w_a[k*Q +: Q]} - {1'b0, y[k*Q +: Q]}
         - {{Q{1'b0}}, w_ci})
      : ({1'b0, w_a[k*Q +: Q]} + {1'b0, y[k*Q +: Q]}
         + {{Q{1'b0}}, w_ci});
  end

  // Pick the lane split; mode 3 falls back to a single lane.
  always_comb begin
    w_z = w_s1[DW-1:0];
    w_c = {3'b000, w_s1[DW]};
    case (simd)
      2'd1: begin
        for (int i = 0; i < 2; i++) begin
          w_z[i*H +: H] = w_s2[i][H-1:0];
          w_c[i]        = w_s2[i][H];
        end
      end
      2'd2: begin
        for (int i = 0; i < 4; i++) begin
          w_z[i*Q +: Q] = w_s4[i][Q-1:0];
          w_c[i]        = w_s4[i][Q];
        end
      end
      default: ;
    endcase
  end

  // Stage 1: result/accumulator loads only on valid samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_z    <= '0;
      r_cout <= '0;
      r_v    <= 1'b0;
    end else if (CE) begin
      r_v <= in_valid;
      if (in_valid) begin
        r_z    <= w_z;
        r_cout <= w_c;
      end
    end
  end

  if (PIPE_STAGES > 1) begin : g_dly
    localparam int D = PIPE_STAGES - 1;
    logic [DW-1:0] r_dz [D];
    logic [3:0]    r_dc [D];
    logic          r_dv [D];

    // Pure delay stages behind stage 1.
    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int i = 0; i < D; i++) begin
          r_dz[i] <= '0;
          r_dc[i] <= '0;
          r_dv[i] <= 1'b0;
        end
      end else if (CE) begin
        r_dz[0] <= r_z;
        r_dc[0] <= r_cout;
        r_dv[0] <= r_v;
        for (int i = 1; i < D; i++) begin
          r_dz[i] <= r_dz[i-1];
          r_dc[i] <= r_dc[i-1];
          r_dv[i] <= r_dv[i-1];
        end
      end
    end

    assign z         = r_dz[D-1];
    assign cout      = r_dc[D-1];
    assign out_valid = r_dv[D-1];
  end else begin : g_nodly
    assign z         = r_z;
    assign cout      = r_cout;
    assign out_valid = r_v;
  end
endmodule

// File: tb/tb_simd_add_sub_pipe.sv
// Scoreboard bench: one stimulus stream drives three pipeline
// depths (2, 1, 4); each has its own queue and monitor.
module tb_simd_add_sub_pipe;
  typedef struct packed {
    logic [47:0] z;
    logic [3:0]  c;
    int          issue;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST, CE, in_valid, opmode, acc_en, cin;
  logic [1:0]  simd;
  logic [47:0] x, y;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (CE && !RST) edge_cnt <= edge_cnt + 1;

  for (genvar g = 0; g < 3; g++) begin : g_d
    localparam int P = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    exp_t        q[$];
    logic [47:0] z_w;
    logic [3:0]  c_w;
    logic        v_w;

    simd_add_sub_pipe #(.DATA_WIDTH(48), .PIPE_STAGES(P)) u_dut (
      .CLK(CLK), .RST(RST), .CE(CE), .in_valid(in_valid),
      .opmode(opmode), .acc_en(acc_en), .simd(simd),
      .x(x), .y(y), .cin(cin),
      .z(z_w), .cout(c_w), .out_valid(v_w)
    );

    initial begin : mon
      logic        rs, cs, pv;
      logic [47:0] pz;
      logic [3:0]  pc;
      exp_t        e;
      pz = '0; pc = '0; pv = 1'b0;
      forever begin
        @(posedge CLK);
        rs = RST;
        cs = CE;
        #1;
        if (rs) begin
          total++;
          if (z_w !== 48'h0 || c_w !== 4'h0 || v_w !== 1'b0) begin
            bad++;
            $display("FAIL reset P=%0d: z=%h c=%b v=%b need 0/0/0",
                     P, z_w, c_w, v_w);
          end
        end else if (!cs) begin
          total++;
          if (z_w !== pz || c_w !== pc || v_w !== pv) begin
            bad++;
            $display("FAIL stall P=%0d: z=%h c=%b v=%b need %h/%b/%b",
                     P, z_w, c_w, v_w, pz, pc, pv);
          end
        end else if (v_w === 1'b1) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL extra P=%0d: z=%h with empty queue", P, z_w);
          end else begin
            e = q.pop_front();
            if (z_w !== e.z || c_w !== e.c ||
                edge_cnt - e.issue != P) begin
              bad++;
              $display("FAIL result P=%0d: z=%h c=%b lat=%0d need %h/%b/%0d",
                       P, z_w, c_w, edge_cnt - e.issue, e.z, e.c, P);
            end
          end
        end
        pz = z_w; pc = c_w; pv = v_w;
      end
    end
  end

  task automatic step(input logic rst, input logic ce,
                      input logic v, input logic op,
                      input logic acc, input logic [1:0] sm,
                      input logic [47:0] xx, input logic [47:0] yy,
                      input logic ci, input logic [47:0] ez,
                      input logic [3:0] ec);
    exp_t e;
    @(negedge CLK);
    RST = rst; CE = ce; in_valid = v; opmode = op;
    acc_en = acc; simd = sm; x = xx; y = yy; cin = ci;
    e.z = ez; e.c = ec; e.issue = edge_cnt;
    if (rst) begin
      g_d[0].q.delete();
      g_d[1].q.delete();
      g_d[2].q.delete();
    end else if (ce && v) begin
      g_d[0].q.push_back(e);
      g_d[1].q.push_back(e);
      g_d[2].q.push_back(e);
    end
  endtask

  initial begin
    RST = 1'b1; CE = 1'b1; in_valid = 1'b1; opmode = 1'b0;
    acc_en = 1'b0; simd = 2'd0; x = 48'h1; y = 48'h1; cin = 1'b0;
    // reset with valid traffic present
    step(1, 1, 1, 0, 0, 0, 48'h7, 48'h9, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 48'h7, 48'h9, 1, 0, 0);
    // ONE add carry out
    step(0, 1, 1, 0, 0, 0, 48'hFFFF_FFFF_FFFF, 48'h0, 1,
         48'h0, 4'b0001);
    // FOUR sub with borrows
    step(0, 1, 1, 1, 0, 2, 48'h000_005_FFF_003,
         48'h001_003_001_003, 1, 48'hFFF_002_FFE_FFF, 4'b1001);
    // TWO add, no carry across lanes
    step(0, 1, 1, 0, 0, 1, 48'h000000_FFFFFF, 48'h1, 0,
         48'h0, 4'b0001);
    // TWO sub, borrow stays in lane 0
    step(0, 1, 1, 1, 0, 1, 48'h000010_000000,
         48'h000001_000001, 0, 48'h00000F_FFFFFF, 4'b0001);
    // simd=3 behaves as ONE
    step(0, 1, 1, 1, 0, 3, 48'h1, 48'h2, 0,
         48'hFFFF_FFFF_FFFF, 4'b0001);
    // ONE sub with cin, no borrow
    step(0, 1, 1, 1, 0, 0, 48'h10, 48'h5, 1, 48'hA, 4'b0000);
    // FOUR add, every lane carries
    step(0, 1, 1, 0, 0, 2, 48'hFFF_FFF_FFF_FFF,
         48'h001_001_001_001, 0, 48'h0, 4'b1111);
    // sample caught in flight by a reset
    step(0, 1, 1, 0, 0, 0, 48'h1, 48'h1, 0, 48'h2, 4'b0000);
    step(1, 1, 1, 0, 0, 0, 48'h3, 48'h3, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 48'h3, 48'h3, 0, 0, 0);
    // accumulate from a cleared accumulator
    step(0, 1, 1, 0, 1, 0, 48'h123, 48'd5, 0, 48'd5, 4'b0000);
    step(0, 1, 1, 0, 1, 0, 48'h123, 48'd5, 0, 48'd10, 4'b0000);
    step(0, 1, 1, 0, 1, 0, 48'h123, 48'd5, 0, 48'd15, 4'b0000);
    step(0, 1, 1, 0, 1, 0, 48'h123, 48'd5, 0, 48'd20, 4'b0000);
    step(0, 1, 1, 0, 0, 0, 48'd100, 48'd1, 0, 48'd101, 4'b0000);
    step(0, 1, 1, 0, 1, 0, 48'd999, 48'd1, 0, 48'd102, 4'b0000);
    // stream with CE stall and a bubble
    step(0, 1, 1, 0, 0, 0, 48'd16, 48'd1, 0, 48'd17, 4'b0000);
    step(0, 1, 1, 0, 0, 0, 48'd32, 48'd2, 0, 48'd34, 4'b0000);
    step(0, 0, 1, 1, 1, 2, 48'hABC, 48'h77, 1, 0, 0);
    step(0, 0, 1, 1, 1, 2, 48'hABC, 48'h77, 1, 0, 0);
    step(0, 0, 1, 1, 1, 2, 48'hABC, 48'h77, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 48'd48, 48'd3, 0, 48'd51, 4'b0000);
    step(0, 1, 0, 1, 0, 2, 48'hDEAD, 48'hBEEF, 1, 0, 0);
    step(0, 1, 1, 0, 1, 0, 48'd64, 48'd1, 0, 48'd52, 4'b0000);
    step(0, 1, 1, 0, 0, 0, 48'd80, 48'd5, 0, 48'd85, 4'b0000);
    step(0, 1, 1, 0, 0, 0, 48'd96, 48'd6, 0, 48'd102, 4'b0000);
    // drain
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 0, 0, 0, 48'h0, 48'h0, 0, 0, 0);
    @(negedge CLK);
    total++;
    if (g_d[0].q.size() != 0) begin
      bad++;
      $display("FAIL drain P=2: left=%0d need 0", g_d[0].q.size());
    end
    total++;
    if (g_d[1].q.size() != 0) begin
      bad++;
      $display("FAIL drain P=1: left=%0d need 0", g_d[1].q.size());
    end
    total++;
    if (g_d[2].q.size() != 0) begin
      bad++;
      $display("FAIL drain P=4: left=%0d need 0", g_d[2].q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
